// File: rtl/shift_unit_fsm.sv
// rtl/shift_unit_fsm.sv - WIDTH-bit shift/rotate/Galois-LFSR register with start/done handshake
module shift_unit_fsm #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             AMT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             sout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] M_LOAD = 3'd0;
    localparam logic [2:0] M_SHL  = 3'd1;
    localparam logic [2:0] M_SHR  = 3'd2;
    localparam logic [2:0] M_SAR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ROR  = 3'd5;
    localparam logic [2:0] M_LFSR = 3'd6;
    localparam logic [2:0] M_NOP  = 3'd7;

    logic [0:0]       state;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       mode_r;
    logic             sin_r;
    logic [WIDTH:0]   step_res;

    // One single-bit step; result is {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] step(input logic [2:0] m,
                                            input logic [WIDTH-1:0] v,
                                            input logic s);
        logic [WIDTH:0] r;
        r = {v[0], v};
        case (m)
            M_SHL:   r = {v[WIDTH-1], v[WIDTH-2:0], s};
            M_SHR:   r = {v[0], s, v[WIDTH-1:1]};
            M_SAR:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            M_ROL:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   r = {v[0], v[0], v[WIDTH-1:1]};
            M_LFSR:  r = {v[0], (v >> 1) ^ (v[0] ? TAPS : '0)};
            default: r = {v[0], v};
        endcase
        return r;
    endfunction

    assign step_res = step(mode_r, Q, sin_r);
    assign busy     = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_r <= M_LOAD;
            sin_r  <= 1'b0;
            Q      <= RESET_VAL;
            done   <= 1'b0;
            sout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (mode == M_LOAD) begin
                            Q    <= D;
                            done <= 1'b1;
                        end else if (mode == M_NOP || amt == '0) begin
                            done <= 1'b1;
                        end else begin
                            mode_r <= mode;
                            sin_r  <= sin;
                            cnt    <= amt;
                            state  <= S_RUN;
                        end
                    end
                end
                default: begin
                    Q    <= step_res[WIDTH-1:0];
                    sout <= step_res[WIDTH];
                    cnt  <= cnt - 1'b1;
                    // The edge performing the last step also raises done.
                    if (cnt == AMT_W'(1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_fsm.sv
// tb/tb_shift_unit_fsm.sv - scoreboard bench for shift_unit_fsm with directed and random steps
module tb_shift_unit_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [2:0] amt;
    logic [7:0] D;
    logic       sin;
    logic [7:0] Q;
    logic       busy;
    logic       done;
    logic       sout;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        int         lat;
    } exp_t;

    exp_t sb[$];
    logic [7:0] mq;
    logic       ms;
    int         lat_seen;

    shift_unit_fsm dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
        .D(D), .sin(sin), .Q(Q), .busy(busy), .done(done), .sout(sout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_step(input logic [2:0] m, input logic [7:0] v, input logic s);
        case (m)
            3'd1: return {v[7], v[6:0], s};
            3'd2: return {v[0], s, v[7:1]};
            3'd3: return {v[0], v[7], v[7:1]};
            3'd4: return {v[7], v[6:0], v[7]};
            3'd5: return {v[0], v[0], v[7:1]};
            3'd6: return {v[0], (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00)};
            default: return {1'b0, v};
        endcase
    endfunction

    // Runs one operation from IDLE; returns at the done cycle, 1 time unit after its edge.
    task automatic run_op(input logic [2:0] m, input logic [2:0] a, input logic [7:0] d,
                          input logic s, input logic poke);
        exp_t e;
        logic [8:0] r;
        int n;
        @(negedge clk);
        start = 1'b1; mode = m; amt = a; D = d; sin = s;
        if (m == 3'd0) begin
            mq = d;
            e.lat = 0;
        end else if (m == 3'd7 || a == 3'd0) begin
            e.lat = 0;
        end else begin
            for (int i = 0; i < a; i++) begin
                r  = ref_step(m, mq, s);
                mq = r[7:0];
                ms = r[8];
            end
            e.lat = a;
        end
        e.q = mq; e.so = ms;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; mode = 3'd0; D = ~d; sin = ~s; amt = 3'd0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            check("busy_during_run", busy, 1'b1);
            if (poke && n == 1) begin start = 1'b1; mode = 3'd0; D = 8'h00; end
            if (poke && n == 2) start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        lat_seen = n;
        e = sb.pop_front();
        check("done_seen", done, 1'b1);
        check("latency", n, e.lat);
        check("busy_at_done", busy, 1'b0);
        check("q_result", Q, e.q);
        check("sout_result", sout, e.so);
    endtask

    task automatic done_clears;
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; mode = 3'd0; amt = 3'd0; D = 8'hFF; sin = 1'b0;
        mq = 8'h00; ms = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", Q, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sout", sout, 1'b0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("no_accept_in_reset", done, 1'b0);
        check("q_after_reset", Q, 8'h00);

        run_op(3'd0, 3'd0, 8'hA5, 1'b0, 1'b0);
        check("load_a5", Q, 8'hA5);
        done_clears();

        run_op(3'd3, 3'd3, 8'h00, 1'b0, 1'b1);
        check("sar_f4", Q, 8'hF4);
        check("sar_sout", sout, 1'b1);
        done_clears();

        run_op(3'd4, 3'd4, 8'h00, 1'b0, 1'b0);
        check("rol_4f", Q, 8'h4F);
        run_op(3'd1, 3'd1, 8'h00, 1'b1, 1'b0);
        check("b2b_shl_9f", Q, 8'h9F);
        check("b2b_shl_sout", sout, 1'b0);

        run_op(3'd0, 3'd0, 8'h01, 1'b0, 1'b0);
        run_op(3'd6, 3'd1, 8'h00, 1'b0, 1'b0);
        check("lfsr_b8", Q, 8'hB8);
        check("lfsr_sout1", sout, 1'b1);
        run_op(3'd6, 3'd2, 8'h00, 1'b0, 1'b0);
        check("lfsr_2e", Q, 8'h2E);
        check("lfsr_lat2", lat_seen, 2);

        run_op(3'd7, 3'd5, 8'h3C, 1'b1, 1'b0);
        check("nop_q", Q, 8'h2E);

        // Reset in the middle of a long SHL must abandon it silently.
        run_op(3'd0, 3'd0, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; mode = 3'd1; amt = 3'd7; sin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("two_steps_q", Q, 8'h94);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq = 8'h00; ms = 1'b0;
        check("midrst_q", Q, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", done, 1'b0);
        end
        run_op(3'd1, 3'd0, 8'h00, 1'b1, 1'b0);
        check("amt0_q", Q, 8'h00);

        run_op(3'd0, 3'd0, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_op(3'($urandom_range(1, 6)), 3'($urandom_range(0, 7)), 8'($urandom),
                   1'($urandom), 1'b0);
        end
        run_op(3'd5, 3'd7, 8'h00, 1'b0, 1'b0);
        run_op(3'd2, 3'd7, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
